// File: rtl/mxrv_regfile.sv
// Register file with two registered read ports, one writeback port, optional
// same-cycle write-to-read forwarding, and a per-entry pending-write scoreboard.
module mxrv_regfile #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    input  logic          re_i,
    output logic [DW-1:0] rs1_data_o,
    output logic [DW-1:0] rs2_data_o,
    input  logic          we_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [DW-1:0] rd_data_i,
    input  logic          iss_i,
    input  logic [AW-1:0] iss_addr_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] ent_val [NREG];
    logic [NREG-1:0] busy_val;
    logic [AW-1:0] rs_addr [2];
    logic [DW-1:0] rs_data [2];

    // Entry 0 is hardwired: no storage, never written, never busy.
    assign ent_val[0]  = '0;
    assign busy_val[0] = 1'b0;

    // Entries are flops rather than RAM because reset must clear them all.
    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_ent
            logic [DW-1:0] ent_reg;
            logic          busy_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent_reg  <= '0;
                    busy_reg <= 1'b0;
                end else begin
                    if (we_i && rd_addr_i == AW'(gi))
                        ent_reg <= rd_data_i;
                    // A new issue outranks the retiring writeback to the same entry.
                    if (iss_i && iss_addr_i == AW'(gi))
                        busy_reg <= 1'b1;
                    else if (we_i && rd_addr_i == AW'(gi))
                        busy_reg <= 1'b0;
                end
            end

            assign ent_val[gi]  = ent_reg;
            assign busy_val[gi] = busy_reg;
        end
    endgenerate

    assign rs_addr[0] = rs1_addr_i;
    assign rs_addr[1] = rs2_addr_i;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DW-1:0] data_reg;
            logic [DW-1:0] data_next;

            always_comb begin
                data_next = ent_val[rs_addr[gi]];
                if (BYPASS != 0 && we_i && rd_addr_i == rs_addr[gi])
                    data_next = rd_data_i;
                if (rs_addr[gi] == '0)
                    data_next = '0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    data_reg <= '0;
                else if (re_i)
                    data_reg <= data_next;
            end

            assign rs_data[gi] = data_reg;
        end
    endgenerate

    assign rs1_data_o = rs_data[0];
    assign rs2_data_o = rs_data[1];
    assign rs1_busy_o = busy_val[rs1_addr_i];
    assign rs2_busy_o = busy_val[rs2_addr_i];

endmodule
